// File: rtl/window_accumulator.sv
// window_accumulator: sums each consecutive window of WINDOW signed samples
// into a wide signed result held in a one-entry valid/ready output register.
// A flush request closes the open window early and emits the partial sum.
module window_accumulator #(
  parameter int IN_WIDTH  = 4,
  parameter int WINDOW    = 4,
  parameter int OUT_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_b,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic [$clog2(WINDOW):0]     out_count
);

  localparam int CW = $clog2(WINDOW);
  localparam logic [CW-1:0] LAST_CNT = CW'(WINDOW - 1);
  localparam logic [CW:0]   FULL_CNT = (CW + 1)'(WINDOW);

  logic signed [OUT_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        flush_pend_q, flush_pend_d;
  logic                        out_valid_q, out_valid_d;
  logic signed [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic [CW:0]                 out_count_q, out_count_d;

  logic signed [OUT_WIDTH-1:0] sampleExt;
  logic signed [OUT_WIDTH-1:0] runningSum;
  logic [CW:0]                 runningCount;
  logic                        inReady;
  logic                        accept;
  logic                        lastSample;
  logic                        slotFree;
  logic                        flushReq;

  // Handshake qualifiers: the only stall is the completing sample meeting a
  // held result that the consumer is not taking this cycle.
  always_comb begin
    sampleExt    = {{(OUT_WIDTH - IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
    runningSum   = acc_q + sampleExt;
    runningCount = (CW + 1)'(cnt_q) + (CW + 1)'(1);
    lastSample   = (cnt_q == LAST_CNT);
    slotFree     = !out_valid_q || out_ready;
    inReady      = !(lastSample && out_valid_q && !out_ready);
    accept       = in_valid && inReady;
    flushReq     = flush || flush_pend_q;
  end

  // Next-state: window completion has priority, then a serviceable flush,
  // otherwise a plain accumulate; the output slot drains on out_ready.
  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    flush_pend_d = flushReq;
    out_valid_d  = out_valid_q && !out_ready;
    out_data_d   = out_data_q;
    out_count_d  = out_count_q;

    if (accept && lastSample) begin
      out_data_d   = runningSum;
      out_count_d  = FULL_CNT;
      out_valid_d  = 1'b1;
      acc_d        = '0;
      cnt_d        = '0;
      flush_pend_d = 1'b0;
    end else if (flushReq && slotFree) begin
      if (accept) begin
        out_data_d  = runningSum;
        out_count_d = runningCount;
        out_valid_d = 1'b1;
      end else if (cnt_q != '0) begin
        out_data_d  = acc_q;
        out_count_d = (CW + 1)'(cnt_q);
        out_valid_d = 1'b1;
      end
      acc_d        = '0;
      cnt_d        = '0;
      flush_pend_d = 1'b0;
    end else if (accept) begin
      acc_d = runningSum;
      cnt_d = cnt_q + CW'(1);
    end
  end

  // State and output registers; reset discards any partial or held result.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_count_q  <= '0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_count_q  <= out_count_d;
    end
  end

  assign in_ready  = inReady;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_window_accumulator.sv
// Directed table-driven bench for window_accumulator with default parameters.
module tb_window_accumulator;

  logic              clk;
  logic              rst_b;
  logic              in_valid;
  logic              in_ready;
  logic signed [3:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] out_data;
  logic [2:0]        out_count;

  int checks;
  int failures;

  typedef struct {
    logic       valid;
    int         data;
    logic       flush;
    logic       ready;
    logic       expReady;
    logic       expValid;
    int         expData;
    int         expCount;
    string      label;
  } vec_t;

  vec_t vecs[$];

  window_accumulator #(
    .IN_WIDTH(4),
    .WINDOW(4),
    .OUT_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst_b(rst_b),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_count(out_count)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic addVec(input logic v, input int d, input logic f, input logic r,
                        input logic eR, input logic eV, input int eD, input int eC,
                        input string lbl);
    vec_t t;
    t.valid = v; t.data = d; t.flush = f; t.ready = r;
    t.expReady = eR; t.expValid = eV; t.expData = eD; t.expCount = eC;
    t.label = lbl;
    vecs.push_back(t);
  endtask

  // Drives one cycle of inputs, checks in_ready before the edge and the
  // registered outputs just after it. Entered and left at posedge+1.
  task automatic applyStimulus(input vec_t t);
    in_valid  = t.valid;
    in_data   = 4'(t.data);
    flush     = t.flush;
    out_ready = t.ready;
    @(negedge clk);
    checkOutput({t.label, ".in_ready"}, int'(in_ready), int'(t.expReady));
    @(posedge clk);
    #1;
    checkOutput({t.label, ".out_valid"}, int'(out_valid), int'(t.expValid));
    if (t.expValid) begin
      checkOutput({t.label, ".out_data"}, int'($signed(out_data)), t.expData);
      checkOutput({t.label, ".out_count"}, int'(out_count), t.expCount);
    end
  endtask

  task automatic runTable();
    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);
    vecs.delete();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_b = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    flush = 1'b0;
    out_ready = 1'b1;
    #1;
    checkOutput("reset.in_ready", int'(in_ready), 1);
    checkOutput("reset.out_valid", int'(out_valid), 0);
    checkOutput("reset.out_data", int'($signed(out_data)), 0);
    checkOutput("reset.out_count", int'(out_count), 0);
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #1;

    // Full windows, positive, negative and mixed
    addVec(1,  7, 0, 1, 1, 0,  0, 0, "p7a");
    addVec(1,  7, 0, 1, 1, 0,  0, 0, "p7b");
    addVec(1,  7, 0, 1, 1, 0,  0, 0, "p7c");
    addVec(1,  7, 0, 1, 1, 1, 28, 4, "p7d");
    addVec(0,  0, 0, 1, 1, 0,  0, 0, "p7idle");
    addVec(1, -8, 0, 1, 1, 0,  0, 0, "n8a");
    addVec(1, -8, 0, 1, 1, 0,  0, 0, "n8b");
    addVec(1, -8, 0, 1, 1, 0,  0, 0, "n8c");
    addVec(1, -8, 0, 1, 1, 1,-32, 4, "n8d");
    addVec(0,  0, 0, 1, 1, 0,  0, 0, "n8idle");
    addVec(1,  3, 0, 1, 1, 0,  0, 0, "mixa");
    addVec(1, -2, 0, 1, 1, 0,  0, 0, "mixb");
    addVec(1,  5, 0, 1, 1, 0,  0, 0, "mixc");
    addVec(1, -1, 0, 1, 1, 1,  5, 4, "mixd");
    addVec(0,  0, 0, 1, 1, 0,  0, 0, "mixidle");
    // Streaming: eight back-to-back ones
    addVec(1,  1, 0, 1, 1, 0,  0, 0, "st1");
    addVec(1,  1, 0, 1, 1, 0,  0, 0, "st2");
    addVec(1,  1, 0, 1, 1, 0,  0, 0, "st3");
    addVec(1,  1, 0, 1, 1, 1,  4, 4, "st4");
    addVec(1,  1, 0, 1, 1, 0,  0, 0, "st5");
    addVec(1,  1, 0, 1, 1, 0,  0, 0, "st6");
    addVec(1,  1, 0, 1, 1, 0,  0, 0, "st7");
    addVec(1,  1, 0, 1, 1, 1,  4, 4, "st8");
    addVec(0,  0, 0, 1, 1, 0,  0, 0, "stidle");
    // Backpressure: result 4 held, then four samples of 2
    addVec(1,  1, 0, 1, 1, 0,  0, 0, "bp1");
    addVec(1,  1, 0, 1, 1, 0,  0, 0, "bp2");
    addVec(1,  1, 0, 1, 1, 0,  0, 0, "bp3");
    addVec(1,  1, 0, 0, 1, 1,  4, 4, "bp4");
    addVec(1,  2, 0, 0, 1, 1,  4, 4, "bp5");
    addVec(1,  2, 0, 0, 1, 1,  4, 4, "bp6");
    addVec(1,  2, 0, 0, 1, 1,  4, 4, "bp7");
    addVec(1,  2, 0, 0, 0, 1,  4, 4, "bpstall");
    addVec(1,  2, 0, 1, 1, 1,  8, 4, "bpdrain");
    addVec(0,  0, 0, 1, 1, 0,  0, 0, "bpidle");
    // Flush of a partial window
    addVec(1,  2, 0, 1, 1, 0,  0, 0, "fl2");
    addVec(1,  3, 0, 1, 1, 0,  0, 0, "fl3");
    addVec(0,  0, 1, 1, 1, 1,  5, 2, "flgo");
    addVec(0,  0, 0, 1, 1, 0,  0, 0, "flidle");
    // Flush of an empty window, then flush together with a sample
    addVec(0,  0, 1, 1, 1, 0,  0, 0, "flempty");
    addVec(1,  1, 0, 1, 1, 0,  0, 0, "flsa");
    addVec(0,  0, 0, 1, 1, 0,  0, 0, "flnopend");
    addVec(1,  4, 1, 1, 1, 1,  5, 2, "flwith");
    addVec(0,  0, 0, 1, 1, 0,  0, 0, "flwidle");
    // Flush together with a full-window completion
    addVec(1,  1, 0, 1, 1, 0,  0, 0, "fc1");
    addVec(1,  1, 0, 1, 1, 0,  0, 0, "fc2");
    addVec(1,  1, 0, 1, 1, 0,  0, 0, "fc3");
    addVec(1,  1, 1, 1, 1, 1,  4, 4, "fc4");
    addVec(0,  0, 0, 1, 1, 0,  0, 0, "fcidle");
    addVec(0,  0, 0, 1, 1, 0,  0, 0, "fcnoempty");
    // Flush while the output is stalled
    addVec(1,  1, 0, 1, 1, 0,  0, 0, "fs1");
    addVec(1,  1, 0, 1, 1, 0,  0, 0, "fs2");
    addVec(1,  1, 0, 1, 1, 0,  0, 0, "fs3");
    addVec(1,  1, 0, 0, 1, 1,  4, 4, "fs4");
    addVec(1,  3, 0, 0, 1, 1,  4, 4, "fs5");
    addVec(0,  0, 1, 0, 1, 1,  4, 4, "fsflush");
    addVec(0,  0, 0, 0, 1, 1,  4, 4, "fshold");
    addVec(0,  0, 0, 1, 1, 1,  3, 1, "fsdrain");
    addVec(0,  0, 0, 1, 1, 0,  0, 0, "fsidle");
    // Held result plus a partial window, then reset mid-flight
    addVec(1,  1, 0, 1, 1, 0,  0, 0, "rs1");
    addVec(1,  1, 0, 1, 1, 0,  0, 0, "rs2");
    addVec(1,  1, 0, 1, 1, 0,  0, 0, "rs3");
    addVec(1,  1, 0, 0, 1, 1,  4, 4, "rs4");
    addVec(1, -5, 0, 0, 1, 1,  4, 4, "rs5");
    addVec(1, -5, 0, 0, 1, 1,  4, 4, "rs6");
    runTable();

    // Asynchronous reset between clock edges
    in_valid = 1'b0;
    #2;
    rst_b = 1'b0;
    #1;
    checkOutput("asyncrst.in_ready", int'(in_ready), 1);
    checkOutput("asyncrst.out_valid", int'(out_valid), 0);
    checkOutput("asyncrst.out_data", int'($signed(out_data)), 0);
    checkOutput("asyncrst.out_count", int'(out_count), 0);
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #1;

    // The discarded partial must not leak into the next sum
    addVec(1,  1, 0, 1, 1, 0,  0, 0, "ar1");
    addVec(1,  1, 0, 1, 1, 0,  0, 0, "ar2");
    addVec(1,  1, 0, 1, 1, 0,  0, 0, "ar3");
    addVec(1,  1, 0, 1, 1, 1,  4, 4, "ar4");
    addVec(0,  0, 0, 1, 1, 0,  0, 0, "aridle");
    runTable();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/window_accumulator.md
# window_accumulator

Upstream stage of the saturating-narrowing path. Accepts a stream of signed narrow samples over a valid/ready handshake, sums each consecutive window of WINDOW samples into a wide signed result, and presents that result over a registered valid/ready output. The output feeds the saturate stage, which clamps the wide sum back to the narrow symmetric range. An explicit flush emits a partial window early.

## Interface

- Reset: one clock; reset is asynchronous and active-low.
- Parameters:
  - IN_WIDTH, default 4: signed input sample width.
  - WINDOW, default 4: samples per sum; must be ≥2.
  - OUT_WIDTH, default 8: signed sum width; must be ≥ IN_WIDTH + $clog2(WINDOW), so the sum never overflows.
- Ports:
  - clk, input, 1: clock, rising edge.
  - rst_b, input, 1: asynchronous active-low reset.
  - in_valid, input, 1: a sample is offered.
  - in_ready, output, 1: the sample is accepted this cycle.
  - in_data, input, IN_WIDTH: signed sample.
  - flush, input, 1: single-cycle request to close the current window early.
  - out_valid, output, 1: a sum is held.
  - out_ready, input, 1: the consumer takes the sum.
  - out_data, output, OUT_WIDTH: signed sum.
  - out_count, output, $clog2(WINDOW)+1: number of samples in out_data (1..WINDOW).

## Operation

- Internal state:
  - acc: signed, OUT_WIDTH.
  - cnt: samples in the open window, 0..WINDOW-1.
  - flush_pend: sticky flag.
  - A one-entry output register holding out_data, out_count and out_valid.
- Accept: a sample is accepted when in_valid && in_ready. in_data is sign-extended to OUT_WIDTH before it is added.
- Window completes when an accepted sample makes the count reach WINDOW:
  - out_data <= acc + sext(in_data); out_count <= WINDOW; out_valid <= 1.
  - acc <= 0; cnt <= 0.
- Otherwise an accepted sample updates acc <= acc + sext(in_data) and cnt <= cnt+1.
- in_ready is deasserted only when both hold: cnt == WINDOW-1, and out_valid && !out_ready (the output slot cannot be freed this cycle). In every other cycle in_ready = 1.
- Flush:
  - flush sets flush_pend.
  - The flush is serviced in the first cycle where the flush is pending (flush || flush_pend) and the output slot is free (!out_valid || out_ready).
  - A sample accepted in the same cycle as the flush is included in the emitted sum.
  - Emitted: out_data = the partial sum, out_count = the samples so far. acc and cnt are cleared, and flush_pend is cleared.
  - Flush with cnt == 0 and no sample accepted: nothing is emitted and flush_pend is cleared.
  - Flush in the same cycle as a full-window completion: the full window is emitted and flush_pend is cleared. No empty partial is ever emitted.
- Output hold: out_data and out_count stay stable while out_valid && !out_ready. out_valid falls after the transfer unless a new result loads in the same cycle, which allows back-to-back output.
- Arithmetic: two's complement, no saturation in this block.
  - Range with defaults: -32..+28.
  - Clamping is the downstream stage's job.

## Timing

- Reset values: in_ready = 1, out_valid = 0, out_data = 0, out_count = 0. acc, cnt and flush_pend are 0.
- Latency: out_valid rises the cycle after the completing sample (or the serviced flush) is accepted.
- Throughput: one sample per cycle sustained when out_ready = 1. A WINDOW-sample sum is produced every WINDOW cycles with no bubbles.
- Backpressure: the block stalls only on the completing sample. Earlier samples in a window are still accepted while the output is stalled.
- Reset asserted mid-window or with a pending output: all state clears immediately, the partial sum is discarded, and out_valid drops asynchronously.

## Test plan

- WINDOW=4, IN_WIDTH=4, OUT_WIDTH=8, out_ready=1:
  - Inputs 7,7,7,7 -> out_data=28, out_count=4, out_valid exactly one cycle after the 4th accept.
  - Inputs -8,-8,-8,-8 -> out_data=-32.
  - Inputs 3,-2,5,-1 -> out_data=5.
- Streaming: 8 back-to-back samples, all 1, out_ready=1 -> two results of 4, with no in_ready deassertion.
- Backpressure: out_ready=0 with a result of 4 held, then 4 more samples of 2 offered:
  - The first 3 are accepted; in_ready drops on the 4th.
  - Raise out_ready -> 4 is transferred, the 4th sample is accepted, and 8 appears the next cycle.
- Flush:
  - Samples 2,3, then flush -> out_data=5, out_count=2.
  - Flush with an empty window -> no output.
  - Flush together with a sample of 4 after 1 -> out_data=5, out_count=2.
  - Flush while the output is stalled -> the partial is emitted after the drain.
- Reset: assert rst_b=0 after 2 samples (-5,-5) -> all outputs return to their reset values. After release, inputs 1,1,1,1 -> out_data=4, not -6.
